mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter in front of a single-port
// synchronous RAM. One RAM access in flight at a time; data has priority
// except that a waiting fetch is forced through after MAX_DATA_RUN data grants.
//
// state    | meaning
// IDLE     | sample requests, arbitrate, load RAM address/write data
// RD_ISSUE | RAM address presented with ram_we=0, RAM registers read data
// RD_RESP  | read data returned to the granted port with its ready pulse
// WR       | ram_we=1 for one cycle, d_ready pulse, RAM writes on exit edge
// ERR      | bad address, ready+err pulse to the granted port, no RAM access
module mem_arbiter #(
    parameter int AW_WORD      = 12,
    parameter int MAX_DATA_RUN = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_ready,
    output logic [31:0]        if_rdata,
    output logic               if_err,
    input  logic               d_req,
    input  logic               d_we,
    input  logic [31:0]        d_addr,
    input  logic [31:0]        d_wdata,
    output logic               d_ready,
    output logic [31:0]        d_rdata,
    output logic               d_err,
    output logic [AW_WORD-1:0] ram_addr,
    output logic [31:0]        ram_wdata,
    output logic               ram_we,
    input  logic [31:0]        ram_rdata,
    output logic               busy
);

    localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_DATA_RUN);

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_RESP,
        WR,
        ERR
    } state_t;

    state_t             state_q, state_d;
    logic               sel_data_q, sel_data_d;
    logic [RUN_W-1:0]   data_run_q, data_run_d;
    logic [AW_WORD-1:0] ram_addr_d;
    logic [31:0]        ram_wdata_d;
    logic               ram_we_d;

    logic               take_fetch;
    logic               any_grant;
    logic [31:0]        g_addr;
    logic               g_bad;
    logic               g_write;

    // Arbitration decision and address check for the request seen in IDLE.
    assign take_fetch = if_req && (!d_req || (data_run_q == RUN_MAX));
    assign any_grant  = if_req || d_req;
    assign g_addr     = take_fetch ? if_addr : d_addr;
    assign g_bad      = (g_addr[1:0] != 2'b00) || (g_addr[31:AW_WORD+2] != '0);
    assign g_write    = !take_fetch && d_we;

    // State, grant owner, starvation counter and registered RAM controls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sel_data_q <= 1'b0;
            data_run_q <= '0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_we     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_data_q <= sel_data_d;
            data_run_q <= data_run_d;
            ram_addr   <= ram_addr_d;
            ram_wdata  <= ram_wdata_d;
            ram_we     <= ram_we_d;
        end
    end

    // Next-state logic: grant in IDLE, then walk the access sequence back to IDLE.
    always_comb begin
        state_d     = state_q;
        sel_data_d  = sel_data_q;
        data_run_d  = data_run_q;
        ram_addr_d  = ram_addr;
        ram_wdata_d = ram_wdata;
        ram_we_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!if_req) begin
                    data_run_d = '0;
                end
                if (take_fetch) begin
                    sel_data_d = 1'b0;
                    data_run_d = '0;
                end else if (d_req) begin
                    sel_data_d = 1'b1;
                    if (if_req && (data_run_q != RUN_MAX)) begin
                        data_run_d = data_run_q + 1'b1;
                    end
                end
                if (any_grant) begin
                    if (g_bad) begin
                        state_d = ERR;
                    end else begin
                        ram_addr_d = g_addr[AW_WORD+1:2];
                        if (g_write) begin
                            state_d     = WR;
                            ram_we_d    = 1'b1;
                            ram_wdata_d = d_wdata;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: state_d = RD_RESP;
            RD_RESP:  state_d = IDLE;
            WR:       state_d = IDLE;
            ERR:      state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Port responses decoded from the state and the registered grant owner.
    always_comb begin
        logic done;
        logic resp;
        done     = (state_q == RD_RESP) || (state_q == WR) || (state_q == ERR);
        resp     = (state_q == RD_RESP);
        busy     = (state_q != IDLE);
        if_ready = done && !sel_data_q;
        d_ready  = done && sel_data_q;
        if_err   = (state_q == ERR) && !sel_data_q;
        d_err    = (state_q == ERR) && sel_data_q;
        if_rdata = (resp && !sel_data_q) ? ram_rdata : 32'h0;
        d_rdata  = (resp && sel_data_q) ? ram_rdata : 32'h0;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port RAM.
module tb_mem_arbiter;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          if_req = 1'b0;
    logic [31:0]   if_addr = '0;
    logic          if_ready;
    logic [31:0]   if_rdata;
    logic          if_err;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = '0;
    logic [31:0]   d_wdata = '0;
    logic          d_ready;
    logic [31:0]   d_rdata;
    logic          d_err;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic          ram_we;
    logic [31:0]   ram_rdata;
    logic          busy;

    logic [31:0]   mem [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int we_cnt = 0;
    int both_cnt = 0;

    mem_arbiter #(.AW_WORD(AW), .MAX_DATA_RUN(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr),
        .if_ready(if_ready), .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata), .d_err(d_err),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: registered read, write on the edge while ram_we is high.
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        else if (pre_we) mem[pre_addr] <= pre_data;
        ram_rdata <= mem[ram_addr];
    end

    always @(posedge clk) if (ram_we) we_cnt++;
    always @(negedge clk) if (if_ready && d_ready) both_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
        pre_we = 1'b1; pre_addr = a; pre_data = v;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    task automatic settle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("settle_idle", {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int snap;
        int g;
        int cyc;
        string seq;
        string exp_s;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_ram_we", {31'b0, ram_we}, 32'h0);
        chk("rst_ram_addr", {20'b0, ram_addr}, 32'h0);
        chk("rst_ram_wdata", ram_wdata, 32'h0);
        chk("rst_ready", {30'b0, if_ready, d_ready}, 32'h0);
        chk("rst_err", {30'b0, if_err, d_err}, 32'h0);
        rst_n = 1'b1;
        preload(12'd5, 32'hDEADBEEF);
        @(negedge clk);

        // Fetch read of word 5
        snap = we_cnt;
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("f_issue_ready", {31'b0, if_ready}, 32'h0);
        chk("f_issue_busy", {31'b0, busy}, 32'h1);
        chk("f_ram_addr", {20'b0, ram_addr}, 32'h5);
        @(negedge clk);
        chk("f_ready", {31'b0, if_ready}, 32'h1);
        chk("f_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_err", {31'b0, if_err}, 32'h0);
        chk("f_d_ready", {31'b0, d_ready}, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        chk("f_rdata_idle", if_rdata, 32'h0);
        chk("f_no_write", we_cnt - snap, 32'h0);

        // Write 0x12345678 to 0x40, then read it back
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h12345678;
        @(negedge clk);
        chk("w_ready", {31'b0, d_ready}, 32'h1);
        chk("w_ram_we", {31'b0, ram_we}, 32'h1);
        chk("w_ram_addr", {20'b0, ram_addr}, 32'h10);
        chk("w_ram_wdata", ram_wdata, 32'h12345678);
        chk("w_rdata_zero", d_rdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("w_we_drop", {31'b0, ram_we}, 32'h0);
        chk("w_mem", mem[16], 32'h12345678);
        d_req = 1'b1; d_addr = 32'h40;
        @(negedge clk);
        chk("r_issue_ready", {31'b0, d_ready}, 32'h0);
        @(negedge clk);
        chk("r_ready", {31'b0, d_ready}, 32'h1);
        chk("r_rdata", d_rdata, 32'h12345678);
        d_req = 1'b0;
        settle();

        // Error addresses
        snap = we_cnt;
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h41; d_wdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("e_d_ready", {31'b0, d_ready}, 32'h1);
        chk("e_d_err", {31'b0, d_err}, 32'h1);
        chk("e_d_rdata", d_rdata, 32'h0);
        chk("e_ram_addr_hold", {20'b0, ram_addr}, 32'h10);
        chk("e_ram_we", {31'b0, ram_we}, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("e_d_err_clr", {31'b0, d_err}, 32'h0);
        if_req = 1'b1; if_addr = 32'h4000;
        @(negedge clk);
        chk("e_if_ready", {31'b0, if_ready}, 32'h1);
        chk("e_if_err", {31'b0, if_err}, 32'h1);
        chk("e_if_rdata", if_rdata, 32'h0);
        if_req = 1'b0;
        @(negedge clk);
        chk("e_no_write", we_cnt - snap, 32'h0);

        // Contention: both held continuously
        exp_s = "DDDFDDDF";
        seq = "";
        g = 0; cyc = 0;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
        if_req = 1'b1; if_addr = 32'h14;
        while (g < 8 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (d_ready) begin seq = {seq, "D"}; g++; end
            if (if_ready) begin seq = {seq, "F"}; g++; end
        end
        chk("c_count", g, 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < seq.len())
                chk($sformatf("c_grant%0d", i), {24'b0, seq[i]}, {24'b0, exp_s[i]});
            else
                chk($sformatf("c_grant%0d", i), 32'h0, {24'b0, exp_s[i]});
        end
        chk("c_one_ready", both_cnt, 32'h0);
        d_req = 1'b0; if_req = 1'b0;
        settle();

        // Held fetch request across its ready
        if_req = 1'b1; if_addr = 32'h40;
        repeat (2) @(negedge clk);
        chk("h_ready1", {31'b0, if_ready}, 32'h1);
        chk("h_rdata1", if_rdata, 32'h12345678);
        @(negedge clk);
        chk("h_ignored_busy", {31'b0, busy}, 32'h0);
        chk("h_ignored_ready", {31'b0, if_ready}, 32'h0);
        @(negedge clk);
        chk("h_resample_busy", {31'b0, busy}, 32'h1);
        chk("h_resample_ready", {31'b0, if_ready}, 32'h0);
        @(negedge clk);
        chk("h_ready2", {31'b0, if_ready}, 32'h1);
        if_req = 1'b0;
        settle();

        // Reset asserted in the WR cycle
        preload(12'h20, 32'hAAAA5555);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h0BADF00D;
        @(negedge clk);
        chk("rw_in_wr", {31'b0, ram_we}, 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rw_we_drop", {31'b0, ram_we}, 32'h0);
        chk("rw_busy", {31'b0, busy}, 32'h0);
        chk("rw_d_ready", {31'b0, d_ready}, 32'h0);
        chk("rw_ram_addr", {20'b0, ram_addr}, 32'h0);
        chk("rw_ram_wdata", ram_wdata, 32'h0);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);
        chk("rw_mem_kept", mem[32], 32'hAAAA5555);
        chk("rw_no_ready", {31'b0, d_ready}, 32'h0);

        // First request sampled on the first edge after reset release
        rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h14;
        @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 32'h1);
        @(negedge clk);
        chk("post_rst_ready", {31'b0, if_ready}, 32'h1);
        chk("post_rst_rdata", if_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
